// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character LCD write driver.
// Holds the FSM state encoding, LCD word field positions and the init command list.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT
    } lcd_state_t;

    localparam int LCD_ON = 31;
    localparam int LCD_EN = 10;
    localparam int LCD_RS = 9;
    localparam int LCD_RW = 8;

    localparam int INIT_LEN = 4;
    // 8-bit/2-line, display on/cursor off, clear, entry increment
    localparam logic [0:INIT_LEN-1][7:0] INIT_CMDS = {8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear-display and return-home need the long post-write wait.
    function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data[7:1] == 7'b0000001));
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed state of the LCD FSM.
// o_done is high in the last cycle of a loaded count, so a count of N spans N cycles.
module lcd_timer #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RST_COUNT = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_count,
    output logic         o_done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load)
            cnt_d = i_count;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Reset preloads the power-up wait so counting starts on release.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            cnt_q <= RST_COUNT;
        else
            cnt_q <= cnt_d;
    end

    assign o_done = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// Write-side driver for a character LCD: power-up wait, init sequence,
// then byte writes over valid/ready with RS/EN strobe timing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP    = 750000,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_EN_HIGH  = 12,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_CMD_WAIT = 2500,
    parameter int unsigned T_CLR_WAIT = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic        o_init_done,
    output logic [31:0] o_io_lcd
);
    localparam int unsigned MAXP = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN_HIGH, T_HOLD)),
                                        max2(T_CMD_WAIT, T_CLR_WAIT));
    localparam int CW = $clog2(MAXP) + 1;

    if (T_PWRUP == 0 || T_SETUP == 0 || T_EN_HIGH == 0 || T_HOLD == 0 ||
        T_CMD_WAIT == 0 || T_CLR_WAIT == 0) begin : g_bad_timing
        $error("lcd_ctrl: all timing parameters must be at least 1");
    end

    lcd_state_t    state_q;
    logic [2:0]    idx_q;
    logic          rs_q, en_q, on_q, ready_q, init_done_q;
    logic [7:0]    data_q;
    logic          tmr_load, tmr_done;
    logic [CW-1:0] tmr_count;

    lcd_timer #(.W(CW), .RST_COUNT(CW'(T_PWRUP))) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (tmr_load),
        .i_count (tmr_count),
        .o_done  (tmr_done)
    );

    // The timer is reloaded on the same edge the FSM enters the next timed state.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_count = '0;
        case (state_q)
            ST_INIT:  begin tmr_load = 1'b1; tmr_count = CW'(T_SETUP); end
            ST_IDLE:  if (i_valid && ready_q) begin tmr_load = 1'b1; tmr_count = CW'(T_SETUP); end
            ST_SETUP: if (tmr_done) begin tmr_load = 1'b1; tmr_count = CW'(T_EN_HIGH); end
            ST_EN_HI: if (tmr_done) begin tmr_load = 1'b1; tmr_count = CW'(T_HOLD); end
            ST_HOLD:  if (tmr_done) begin
                tmr_load  = 1'b1;
                tmr_count = is_clr_home(rs_q, data_q) ? CW'(T_CLR_WAIT) : CW'(T_CMD_WAIT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_PWRUP;
            idx_q       <= '0;
            rs_q        <= 1'b0;
            data_q      <= '0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            on_q <= 1'b1;
            case (state_q)
                ST_PWRUP: if (tmr_done) state_q <= ST_INIT;
                ST_INIT: begin
                    rs_q    <= 1'b0;
                    data_q  <= INIT_CMDS[idx_q[1:0]];
                    idx_q   <= idx_q + 3'd1;
                    state_q <= ST_SETUP;
                end
                ST_IDLE: if (i_valid && ready_q) begin
                    rs_q    <= i_rs;
                    data_q  <= i_data;
                    ready_q <= 1'b0;
                    state_q <= ST_SETUP;
                end
                ST_SETUP: if (tmr_done) begin
                    en_q    <= 1'b1;
                    state_q <= ST_EN_HI;
                end
                ST_EN_HI: if (tmr_done) begin
                    en_q    <= 1'b0;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: if (tmr_done) state_q <= ST_WAIT;
                ST_WAIT: if (tmr_done) begin
                    if (!init_done_q && idx_q != 3'(INIT_LEN)) begin
                        state_q <= ST_INIT;
                    end else begin
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    always_comb begin
        o_io_lcd         = '0;
        o_io_lcd[LCD_ON] = on_q;
        o_io_lcd[LCD_EN] = en_q;
        o_io_lcd[LCD_RS] = rs_q;
        o_io_lcd[LCD_RW] = 1'b0;
        o_io_lcd[7:0]    = data_q;
    end

    assign o_ready     = ready_q;
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with short timing parameters.
// Table-driven single writes plus hand-written init, busy, back-to-back and reset sequences.
module tb_lcd_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_rs = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        o_ready, o_init_done;
    logic [31:0] o_io_lcd;

    int errors = 0;
    int checks = 0;

    lcd_ctrl #(
        .T_PWRUP(20), .T_SETUP(2), .T_EN_HIGH(3), .T_HOLD(2),
        .T_CMD_WAIT(5), .T_CLR_WAIT(9)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_rs        (i_rs),
        .i_data      (i_data),
        .o_init_done (o_init_done),
        .o_io_lcd    (o_io_lcd)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_rdy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && !o_ready; i++) tick();
        chk("wait_ready", {31'b0, o_ready}, 32'd1);
    endtask

    // Called with reset just released; counts edges until the first o_ready.
    task automatic run_init(input string tag);
        int         rdy_at = 0, pulses = 0, cur_w = 0, bad_w = 0, rs_any = 0, rw_any = 0;
        logic       en, en_prev = 1'b0;
        logic [7:0] seen [4];
        for (int k = 0; k < 4; k++) seen[k] = 8'hxx;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) chk({tag, "_on_after_release"}, {31'b0, o_io_lcd[31]}, 32'd1);
            en = o_io_lcd[10];
            if (en && !en_prev) begin
                if (pulses < 4) seen[pulses] = o_io_lcd[7:0];
                if (o_io_lcd[9]) rs_any++;
                pulses++;
                cur_w = 0;
            end
            if (en) cur_w++;
            if (!en && en_prev && cur_w != 3) bad_w++;
            if (o_io_lcd[8]) rw_any++;
            en_prev = en;
            if (o_ready) begin
                rdy_at = n;
                break;
            end
        end
        chk({tag, "_first_ready_cycle"}, rdy_at, 76);
        chk({tag, "_en_pulses"}, pulses, 4);
        chk({tag, "_cmd0"}, {24'b0, seen[0]}, 32'h38);
        chk({tag, "_cmd1"}, {24'b0, seen[1]}, 32'h0C);
        chk({tag, "_cmd2"}, {24'b0, seen[2]}, 32'h01);
        chk({tag, "_cmd3"}, {24'b0, seen[3]}, 32'h06);
        chk({tag, "_init_rs"}, rs_any, 0);
        chk({tag, "_rw"}, rw_any, 0);
        chk({tag, "_en_width"}, bad_w, 0);
        chk({tag, "_init_done"}, {31'b0, o_init_done}, 32'd1);
    endtask

    // Precondition: o_ready sampled high. k counts cycles after the handshake edge.
    task automatic do_write(input logic rs, input logic [7:0] data,
                            output int rdy_at, output int en_first, output int en_last,
                            output int en_cnt, output int bad_hold);
        rdy_at = 0; en_first = 0; en_last = 0; en_cnt = 0; bad_hold = 0;
        i_valid = 1'b1; i_rs = rs; i_data = data;
        tick();
        i_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (o_io_lcd[9] !== rs || o_io_lcd[7:0] !== data) bad_hold++;
            if (o_io_lcd[10]) begin
                if (en_first == 0) en_first = k;
                en_last = k;
                en_cnt++;
            end
            if (o_ready) begin
                rdy_at = k;
                break;
            end
            tick();
        end
    endtask

    vec_t vecs [7];

    initial begin
        int rdy_at, en_first, en_last, en_cnt, bad_hold;
        int pulses, bad, rdy_hi, xfers;
        logic en_prev;
        logic [7:0] last_data;

        vecs[0] = '{1'b1, 8'h41, 13};
        vecs[1] = '{1'b0, 8'h01, 17};
        vecs[2] = '{1'b0, 8'h80, 13};
        vecs[3] = '{1'b0, 8'h02, 17};
        vecs[4] = '{1'b0, 8'h03, 17};
        vecs[5] = '{1'b1, 8'h01, 13};
        vecs[6] = '{1'b0, 8'h04, 13};

        // Reset state
        repeat (3) tick();
        chk("rst_lcd_word", o_io_lcd, 32'h0);
        chk("rst_ready", {31'b0, o_ready}, 32'd0);
        chk("rst_init_done", {31'b0, o_init_done}, 32'd0);
        i_rst = 1'b0;
        run_init("init");

        // Table-driven single writes
        for (int v = 0; v < 7; v++) begin
            wait_ready();
            do_write(vecs[v].rs, vecs[v].data, rdy_at, en_first, en_last, en_cnt, bad_hold);
            chk($sformatf("w%0d_ready_at", v), rdy_at, vecs[v].exp_rdy);
            chk($sformatf("w%0d_en_first", v), en_first, 3);
            chk($sformatf("w%0d_en_last", v), en_last, 5);
            chk($sformatf("w%0d_en_cnt", v), en_cnt, 3);
            chk($sformatf("w%0d_rs_data_hold", v), bad_hold, 0);
        end

        // i_valid toggling while busy is ignored
        wait_ready();
        i_valid = 1'b1; i_rs = 1'b0; i_data = 8'h80;
        tick();
        pulses = 0; bad = 0; rdy_at = 0; en_prev = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (o_io_lcd[10] && !en_prev) pulses++;
            en_prev = o_io_lcd[10];
            if (o_io_lcd[7:0] !== 8'h80 || o_io_lcd[9] !== 1'b0) bad++;
            if (o_ready) begin
                rdy_at = k;
                i_valid = 1'b0;
                break;
            end
            i_rs = 1'b1; i_data = 8'h55; i_valid = k[0];
            tick();
        end
        tick();
        chk("busy_ready_at", rdy_at, 13);
        chk("busy_en_pulses", pulses, 1);
        chk("busy_data_held", bad, 0);
        chk("busy_data_after", {24'b0, o_io_lcd[7:0]}, 32'h80);
        chk("busy_still_ready", {31'b0, o_ready}, 32'd1);

        // Back-to-back writes with i_valid held high
        wait_ready();
        pulses = 0; rdy_hi = 0; xfers = 0; en_prev = 1'b0; last_data = 8'h00;
        i_valid = 1'b1; i_rs = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (o_ready) begin
                rdy_hi++;
                if (xfers == 5) begin
                    i_valid = 1'b0;
                    break;
                end
                i_data = 8'h30 + 8'(xfers);
                xfers++;
            end
            tick();
            if (o_io_lcd[10] && !en_prev) begin
                pulses++;
                last_data = o_io_lcd[7:0];
            end
            en_prev = o_io_lcd[10];
        end
        chk("b2b_en_pulses", pulses, 5);
        chk("b2b_ready_cycles", rdy_hi, 6);
        chk("b2b_last_data", {24'b0, last_data}, 32'h34);

        // Reset while EN is high aborts and reruns power-up and init
        wait_ready();
        i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h5A;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 10 && !o_io_lcd[10]; k++) tick();
        chk("mid_en_seen", {31'b0, o_io_lcd[10]}, 32'd1);
        i_rst = 1'b1;
        tick();
        chk("mid_rst_lcd_word", o_io_lcd, 32'h0);
        chk("mid_rst_ready", {31'b0, o_ready}, 32'd0);
        chk("mid_rst_init_done", {31'b0, o_init_done}, 32'd0);
        i_rst = 1'b0;
        run_init("reinit");

        // A normal write still works after the re-init
        do_write(1'b1, 8'h41, rdy_at, en_first, en_last, en_cnt, bad_hold);
        chk("post_ready_at", rdy_at, 13);
        chk("post_en_first", en_first, 3);
        chk("post_hold", bad_hold, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Write-side driver for the HD44780-style character LCD attached to the board I/O. It accepts byte-wide command/data writes over a valid/ready handshake from the processor's I/O path. It also runs the mandatory power-up wait and initialisation sequence on its own. It generates the RS/RW/EN strobe timing and emits the packed 32-bit LCD word that the board-level LCD pins are driven from.

## Interface
Parameters:
- T_PWRUP, 750000: cycles to wait after reset before the first init write (15 ms at 50 MHz).
- T_SETUP, 2: cycles RS/DATA are stable with EN low before the EN rising edge.
- T_EN_HIGH, 12: cycles EN is held high.
- T_HOLD, 2: cycles RS/DATA are held with EN low after the EN falling edge.
- T_CMD_WAIT, 2500: post-write busy cycles for ordinary commands and data.
- T_CLR_WAIT, 82000: post-write busy cycles for clear-display (0x01) and return-home (0x02/0x03).

Ports:
- i_clk, in, 1: clock, rising edge. Reset is synchronous and active-high.
- i_rst, in, 1: synchronous active-high reset.
- i_valid, in, 1: write request.
- o_ready, out, 1: the block can accept a write this cycle.
- i_rs, in, 1: 0 = command, 1 = character data.
- i_data, in, 8: byte to write.
- o_init_done, out, 1: the init sequence has completed; stays high until reset.
- o_io_lcd, out, 32: packed LCD word with fields [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA. All other bits are 0.

## Operation
- Transfer occurs when i_valid && o_ready are both high on a rising edge. i_rs and i_data are captured on that edge.
- o_ready is high only in IDLE with o_init_done=1. It is never high during a transaction.
- RW is always 0. The block is write-only and never polls the busy flag.
- FSM states: PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
  - PWRUP: count T_PWRUP cycles, then go to INIT.
  - INIT: load the next init command with RS=0, then go to SETUP. The commands in order are 0x38 (8-bit, 2-line), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment).
  - SETUP: hold for T_SETUP cycles, then EN_HI.
  - EN_HI: hold for T_EN_HIGH cycles, then HOLD.
  - HOLD: hold for T_HOLD cycles, then WAIT.
  - WAIT: count the selected wait, then return. Return goes to INIT if init commands remain; otherwise to IDLE, setting o_init_done on that transition.
  - IDLE: on a handshake, go to SETUP.
- Wait selection: T_CLR_WAIT applies when RS=0 and (DATA==0x01 or DATA[7:1]==7'b0000001). Every other write uses T_CMD_WAIT.
- The registered RS/DATA outputs stay unchanged from SETUP through the end of WAIT. In IDLE they keep the last written value.
- EN is 1 only in EN_HI.
- ON=1 in every state after reset is released.
- i_valid during a busy state is ignored. It is not queued; the requester must hold it until o_ready.

## Timing
- All outputs are registered.
- Reset values: o_io_lcd = 32'h0, o_ready = 0, o_init_done = 0, FSM = PWRUP.
- ON rises on the first cycle after i_rst deasserts.
- A handshake at edge N gives:
  - o_ready = 0 from cycle N+1.
  - RS/DATA valid from cycle N+1.
  - EN high in cycles N+1+T_SETUP through N+T_SETUP+T_EN_HIGH.
  - o_ready = 1 again at cycle N+1+T_SETUP+T_EN_HIGH+T_HOLD+wait.
- First o_ready = 1 occurs T_PWRUP + 3*(T_SETUP+T_EN_HIGH+T_HOLD+T_CMD_WAIT) + (T_SETUP+T_EN_HIGH+T_HOLD+T_CLR_WAIT) + 4 cycles after reset release. The +4 is one INIT cycle per command. The bench checks this exact figure.
- Counter width is $clog2 of the largest parameter plus 1. A parameter value of 1 gives exactly one cycle in that state. A value of 0 is illegal; an elaboration-time assertion enforces this.
- i_rst asserted mid-transaction (including with EN high): on the next edge all outputs return to reset values. The partial write is abandoned, and power-up plus init rerun in full.
- i_valid asserted on the same edge that sets o_ready: not a transfer. The transfer happens on the following edge if i_valid is still high.

## Structure
- Package lcd_pkg holds:
  - the state enum;
  - field-position localparams (LCD_ON=31, LCD_EN=10, LCD_RS=9, LCD_RW=8);
  - the init command array and its length (4);
  - the clear/home decode function.
- Sub-module lcd_timer is a loadable down-counter. Inputs: i_clk, i_rst, i_load, i_count. Output: o_done, high in the final counted cycle. One instance is shared by all timed states.
- The top FSM, capture registers and init index live in lcd_ctrl.

## Test plan
Simulation uses T_PWRUP=20, T_SETUP=2, T_EN_HIGH=3, T_HOLD=2, T_CMD_WAIT=5, T_CLR_WAIT=9.
- Release reset and record the init sequence:
  - exactly 4 EN pulses carrying DATA 0x38, 0x0C, 0x01, 0x06 with RS=0;
  - each EN pulse is 3 cycles wide;
  - first o_ready occurs 20+3*12+16+4 = 76 cycles after reset release.
- Write i_rs=1, i_data=0x41:
  - RS=1 and DATA=0x41 the next cycle;
  - EN high exactly cycles +3..+5;
  - o_ready returns at +13.
- Write command 0x01, then command 0x80: the clear uses a 9-cycle wait (o_ready at +17) and 0x80 uses a 5-cycle wait.
- Toggle i_valid with data 0x55 while busy: no extra EN pulse, and DATA is unchanged until the next handshake.
- Assert i_rst for one cycle while EN=1: o_io_lcd=0 the next cycle, then the full power-up wait and 4-command init repeat.
- Hold i_valid high continuously across back-to-back writes: exactly one transfer per o_ready assertion, and 5 writes produce 5 EN pulses.
